seq_engine: RTL and testbench

SEQ_ENGINE -- requirements
Module: seq_engine

---
 rtl/seq_engine_pkg.sv | 44 ++++
 rtl/seq_lfsr.sv | 36 +++
 rtl/seq_engine.sv | 203 ++++++++++++++++++++
 tb/tb_seq_engine.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_engine_pkg.sv
// ============================================================================
// Module   : seq_engine_pkg
// Brief    : Shared state encoding, sizing constants, LFSR taps and the
//            level-to-length helper for the sequence memory game engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_engine_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GEN   = 3'd1,
        S_SHOW  = 3'd2,
        S_GAP   = 3'd3,
        S_INPUT = 3'd4
    } state_t;

    localparam int MAX_LEN    = 8;
    localparam int MAX_LEVEL  = 5;
    localparam int LEN_OFFSET = 3;

    localparam int LFSR_W    = 16;
    localparam int LFSR_TAP0 = 15;
    localparam int LFSR_TAP1 = 13;
    localparam int LFSR_TAP2 = 12;
    localparam int LFSR_TAP3 = 10;

    // Level is clamped into 1..MAX_LEVEL before the offset is added.
    function automatic logic [3:0] calc_len(input logic [3:0] level);
        logic [3:0] clamped;
        if (level == 4'd0) begin
            clamped = 4'd1;
        end else if (level > 4'(MAX_LEVEL)) begin
            clamped = 4'(MAX_LEVEL);
        end else begin
            clamped = level;
        end
        return clamped + 4'(LEN_OFFSET);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_lfsr.sv
// ============================================================================
// Module   : seq_lfsr
// Brief    : Free-running 16-bit Fibonacci LFSR, taps 16/14/13/11.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_lfsr
    import seq_engine_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] o_lfsr
);

    logic [LFSR_W-1:0] r_lfsr;
    logic              w_fb;

    assign w_fb = r_lfsr[LFSR_TAP0] ^ r_lfsr[LFSR_TAP1] ^
                  r_lfsr[LFSR_TAP2] ^ r_lfsr[LFSR_TAP3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/seq_engine.sv
// ============================================================================
// Module   : seq_engine
// Brief    : Simon-style sequence engine: generate, show, then check entries.
//            Optional replay support is enabled by SEQ_ENGINE_REPLAY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_engine
    import seq_engine_pkg::*;
#(
    parameter int                SHOW_TICKS = 8,
    parameter int                GAP_TICKS  = 2,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] currentlevel,
    input  logic       tick,
    input  logic       psub_b,
    input  logic [3:0] player_val,
    input  logic       replay_b,
    output logic [3:0] disp_val,
    output logic       disp_on,
    output logic       accepting,
    output logic       correct,
    output logic       incorrect,
    output logic       busy
);

    localparam int CNT_MAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(MAX_LEN);

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [3:0]       r_len, w_len_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_mem [MAX_LEN];
    logic             w_mem_we;
    logic             r_correct, w_correct_nxt;
    logic             r_incorrect, w_incorrect_nxt;
    logic             w_last;
    logic             w_replay_req;
    logic [LFSR_W-1:0] w_lfsr;
    logic             w_lfsr_unused;

    seq_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .o_lfsr (w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr[LFSR_W-1:4];
    assign w_last        = ({1'b0, r_idx} == (r_len - 4'd1));

`ifdef SEQ_ENGINE_REPLAY_EN
    logic r_replayed;

    assign w_replay_req = replay_b && !psub_b && !r_replayed;

    // One replay per round; the flag rearms whenever the engine is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_replayed <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_replayed <= 1'b0;
        end else if (r_state == S_INPUT && w_replay_req && !abort) begin
            r_replayed <= 1'b1;
        end
    end
`else
    logic w_replay_unused;

    assign w_replay_unused = replay_b;
    assign w_replay_req    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_correct   <= 1'b0;
            r_incorrect <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_len       <= w_len_nxt;
            r_cnt       <= w_cnt_nxt;
            r_correct   <= w_correct_nxt;
            r_incorrect <= w_incorrect_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            r_mem[r_idx] <= w_lfsr[3:0];
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_len_nxt       = r_len;
        w_cnt_nxt       = r_cnt;
        w_mem_we        = 1'b0;
        w_correct_nxt   = 1'b0;
        w_incorrect_nxt = 1'b0;

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_len_nxt   = calc_len(currentlevel);
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_GEN;
                    end
                end
                S_GEN: begin
                    w_mem_we = 1'b1;
                    if (w_last) begin
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_SHOW;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
                S_SHOW: begin
                    if (tick) begin
                        if (r_cnt == CNT_W'(SHOW_TICKS - 1)) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_GAP;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (r_cnt == CNT_W'(GAP_TICKS - 1)) begin
                            w_cnt_nxt = '0;
                            if (w_last) begin
                                w_idx_nxt   = '0;
                                w_state_nxt = S_INPUT;
                            end else begin
                                w_idx_nxt   = r_idx + IDX_W'(1);
                                w_state_nxt = S_SHOW;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_INPUT: begin
                    if (psub_b) begin
                        if (player_val != r_mem[r_idx]) begin
                            w_incorrect_nxt = 1'b1;
                            w_state_nxt     = S_IDLE;
                        end else if (w_last) begin
                            w_correct_nxt = 1'b1;
                            w_state_nxt   = S_IDLE;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end else if (w_replay_req) begin
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_SHOW;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign disp_on   = (r_state == S_SHOW);
    assign disp_val  = disp_on ? r_mem[r_idx] : 4'd0;
    assign accepting = (r_state == S_INPUT);
    assign busy      = (r_state != S_IDLE);
    assign correct   = r_correct;
    assign incorrect = r_incorrect;

endmodule

`default_nettype wire

// File: tb/tb_seq_engine.sv
// ============================================================================
// Module   : tb_seq_engine
// Brief    : Directed, table-driven bench for seq_engine with an LFSR model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_engine;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] currentlevel;
    logic       tick;
    logic       psub_b;
    logic [3:0] player_val;
    logic       replay_b;
    logic [3:0] disp_val;
    logic       disp_on;
    logic       accepting;
    logic       correct;
    logic       incorrect;
    logic       busy;

    int n_checks;
    int n_fail;
    int n_cor;
    int n_inc;

    logic [15:0] m_lfsr;
    logic [3:0]  exp_mem [8];

    typedef struct {
        logic [3:0] level;
        int         len;
        int         err_idx;
        bit         stall;
        bit         start_in_show;
    } vec_t;

    vec_t vt [5];

    seq_engine #(
        .SHOW_TICKS (8),
        .GAP_TICKS  (2),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .currentlevel (currentlevel),
        .tick         (tick),
        .psub_b       (psub_b),
        .player_val   (player_val),
        .replay_b     (replay_b),
        .disp_val     (disp_val),
        .disp_on      (disp_on),
        .accepting    (accepting),
        .correct      (correct),
        .incorrect    (incorrect),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR, stepped on the same edges as the design.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr <= 16'hACE1;
        end else begin
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    always @(negedge clk) begin
        if (correct)   n_cor <= n_cor + 1;
        if (incorrect) n_inc <= n_inc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic gen_phase(input logic [3:0] level, input int len);
        currentlevel = level;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < len; i++) begin
            check("gen_busy", busy, 1);
            check("gen_disp_off", disp_on, 0);
            exp_mem[i] = m_lfsr[3:0];
            step();
        end
        check("disp_first_on", disp_on, 1);
    endtask

    task automatic show_phase(input int len, input bit stall, input bit sis, input int abort_e);
        for (int e = 0; e < len; e++) begin
            if (e == 0 && stall) begin
                tick = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    check("stall_disp_on", disp_on, 1);
                    check("stall_disp_val", disp_val, exp_mem[e]);
                    step();
                end
                tick = 1'b1;
            end
            for (int t = 0; t < 8; t++) begin
                check("show_disp_on", disp_on, 1);
                check("show_disp_val", disp_val, exp_mem[e]);
                check("show_accepting", accepting, 0);
                if (e == abort_e && t == 2) begin
                    abort = 1'b1;
                    step();
                    abort = 1'b0;
                    check("abort_busy", busy, 0);
                    check("abort_disp_on", disp_on, 0);
                    check("abort_accepting", accepting, 0);
                    return;
                end
                if (e == 1 && t == 0 && sis) begin
                    start = 1'b1;
                    currentlevel = 4'd5;
                end
                step();
                start = 1'b0;
            end
            for (int t = 0; t < 2; t++) begin
                check("gap_disp_on", disp_on, 0);
                check("gap_disp_val", disp_val, 0);
                check("gap_busy", busy, 1);
                step();
            end
        end
        check("input_accepting", accepting, 1);
        check("input_disp_on", disp_on, 0);
    endtask

    task automatic enter(input int len, input int err, input int first, input int upto);
        int  c0;
        int  i0;
        bit  done;
        c0   = n_cor;
        i0   = n_inc;
        done = 1'b0;
        for (int i = first; i < upto && !done; i++) begin
            check("entry_accepting", accepting, 1);
            player_val = (i == err) ? (exp_mem[i] ^ 4'h5) : exp_mem[i];
            psub_b = 1'b1;
            step();
            psub_b = 1'b0;
            if (i == err) begin
                check("incorrect_pulse", incorrect, 1);
                check("incorrect_no_correct", correct, 0);
                check("incorrect_idle", busy, 0);
                done = 1'b1;
            end else if (i == len - 1) begin
                check("correct_pulse", correct, 1);
                check("correct_no_incorrect", incorrect, 0);
                check("correct_idle", busy, 0);
                done = 1'b1;
            end else begin
                check("mid_correct", correct, 0);
                check("mid_incorrect", incorrect, 0);
            end
        end
        if (done) begin
            step();
            check("pulse_end_correct", correct, 0);
            check("pulse_end_incorrect", incorrect, 0);
            check("round_correct_count", n_cor - c0, (err >= 0) ? 0 : 1);
            check("round_incorrect_count", n_inc - i0, (err >= 0) ? 1 : 0);
        end
    endtask

    task automatic run_round(input vec_t v);
        int c0;
        int i0;
        gen_phase(v.level, v.len);
        show_phase(v.len, v.stall, v.start_in_show, -1);
        enter(v.len, v.err_idx, 0, v.len);
        c0 = n_cor;
        i0 = n_inc;
        player_val = exp_mem[0];
        psub_b = 1'b1;
        step();
        psub_b = 1'b0;
        step();
        check("idle_psub_busy", busy, 0);
        check("idle_psub_pulses", (n_cor - c0) + (n_inc - i0), 0);
    endtask

    initial begin
        int c0;
        int i0;
        n_checks = 0;
        n_fail = 0;
        n_cor = 0;
        n_inc = 0;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        currentlevel = 4'd0;
        tick = 1'b1;
        psub_b = 1'b0;
        player_val = 4'd0;
        replay_b = 1'b0;

        vt[0] = '{level: 4'd1,  len: 4, err_idx: -1, stall: 1'b1, start_in_show: 1'b0};
        vt[1] = '{level: 4'd5,  len: 8, err_idx: 3,  stall: 1'b0, start_in_show: 1'b0};
        vt[2] = '{level: 4'd0,  len: 4, err_idx: 0,  stall: 1'b0, start_in_show: 1'b1};
        vt[3] = '{level: 4'd9,  len: 8, err_idx: -1, stall: 1'b0, start_in_show: 1'b0};
        vt[4] = '{level: 4'd3,  len: 6, err_idx: 5,  stall: 1'b1, start_in_show: 1'b0};

        #1;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_disp_on", disp_on, 0);
        check("rst_disp_val", disp_val, 0);
        check("rst_accepting", accepting, 0);
        check("rst_correct", correct, 0);
        check("rst_incorrect", incorrect, 0);
        rst = 1'b1;
        step();

        for (int k = 0; k < 5; k++) begin
            run_round(vt[k]);
        end

        // Abort part-way through showing the third element.
        c0 = n_cor;
        i0 = n_inc;
        gen_phase(4'd1, 4);
        show_phase(4, 1'b0, 1'b0, 2);
        step();
        step();
        check("abort_stays_idle", busy, 0);
        check("abort_no_pulses", (n_cor - c0) + (n_inc - i0), 0);
        run_round(vt[0]);

        // Reset in the middle of a round.
        c0 = n_cor;
        i0 = n_inc;
        gen_phase(4'd2, 5);
        step();
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_disp_on", disp_on, 0);
        check("midrst_disp_val", disp_val, 0);
        step();
        rst = 1'b1;
        step();
        check("midrst_no_pulses", (n_cor - c0) + (n_inc - i0), 0);
        run_round(vt[3]);

        // Replay request after two correct entries.
        gen_phase(4'd1, 4);
        show_phase(4, 1'b0, 1'b0, -1);
        enter(4, -1, 0, 2);
        replay_b = 1'b1;
        step();
        replay_b = 1'b0;
`ifdef SEQ_ENGINE_REPLAY_EN
        check("replay_show", disp_on, 1);
        check("replay_not_accepting", accepting, 0);
        show_phase(4, 1'b0, 1'b0, -1);
        replay_b = 1'b1;
        step();
        replay_b = 1'b0;
        check("replay2_ignored_acc", accepting, 1);
        check("replay2_ignored_disp", disp_on, 0);
        enter(4, -1, 0, 4);
`else
        check("replay_ignored_acc", accepting, 1);
        check("replay_ignored_disp", disp_on, 0);
        enter(4, -1, 2, 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
